// File: rtl/noc_packet_sink.sv
// Router local-port packet sink: assembles fixed-length packets from a flit
// stream into a multi-slot buffer, flags misrouted packets, and presents the
// oldest completed packet word-addressably with saturating statistics.
module noc_packet_sink #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PKT_LEN = 8,
  parameter int unsigned COORD_W = 7,
  parameter int unsigned LOCAL_X = 0,
  parameter int unsigned LOCAL_Y = 0,
  parameter int unsigned PKT_BUF = 2,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  input  logic [$clog2(PKT_LEN)-1:0] rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [COORD_W-1:0]         pkt_src_x,
  output logic [COORD_W-1:0]         pkt_src_y,
  output logic                       pkt_misroute,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [CNT_W-1:0]           err_count,
  output logic [CNT_W-1:0]           abort_count
);

  localparam int unsigned IDX_W    = $clog2(PKT_LEN);
  localparam int unsigned PTR_W    = (PKT_BUF > 1) ? $clog2(PKT_BUF) : 1;
  localparam int unsigned OCC_W    = $clog2(PKT_BUF + 1);
  localparam int unsigned TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TMR_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned DEPTH    = PKT_BUF * PKT_LEN;
  localparam int unsigned ADDR_W   = $clog2(DEPTH);

  // Head-word field positions, packed from the MSB down.
  localparam int unsigned XD_LSB = DATA_W - COORD_W;
  localparam int unsigned YD_LSB = DATA_W - 2 * COORD_W;
  localparam int unsigned XS_LSB = DATA_W - 3 * COORD_W;
  localparam int unsigned YS_LSB = DATA_W - 4 * COORD_W;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBody = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] word_cnt_q, word_cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  logic [COORD_W-1:0] hd_xs_q, hd_ys_q;
  logic               hd_mis_q;

  logic [DATA_W-1:0]  mem        [DEPTH];
  logic [COORD_W-1:0] slot_xs_q  [PKT_BUF];
  logic [COORD_W-1:0] slot_ys_q  [PKT_BUF];
  logic               slot_mis_q [PKT_BUF];

  logic              accept, pop, last_word, commit, timeout_hit, abort, head_mis;
  logic [IDX_W-1:0]  wr_word;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (PKT_BUF == 1) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign in_ready  = (occ_q < OCC_W'(PKT_BUF));
  assign pkt_valid = (occ_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = pkt_valid & pkt_ready;
  assign last_word = (state_q == StBody) && (word_cnt_q == IDX_W'(PKT_LEN - 1));
  assign commit    = accept & last_word;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == StBody) && !accept &&
                       (tmr_q == TMR_W'(TMR_LAST));
  assign head_mis  = (in_data[XD_LSB +: COORD_W] != COORD_W'(LOCAL_X)) ||
                     (in_data[YD_LSB +: COORD_W] != COORD_W'(LOCAL_Y));

  assign wr_word = (state_q == StIdle) ? '0 : word_cnt_q;
  assign wr_addr = ADDR_W'(int'(wr_ptr_q) * int'(PKT_LEN) + int'(wr_word));
  assign rd_addr = ADDR_W'(int'(rd_ptr_q) * int'(PKT_LEN) + int'(rd_idx));

  // Assembly FSM next state: word counter and mid-packet idle timer.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    tmr_d      = tmr_q;
    abort      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StBody;
          word_cnt_d = IDX_W'(1);
          tmr_d      = '0;
        end
      end
      StBody: begin
        if (accept) begin
          tmr_d = '0;
          if (last_word) begin
            state_d    = StIdle;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + IDX_W'(1);
          end
        end else if (timeout_hit) begin
          state_d    = StIdle;
          word_cnt_d = '0;
          tmr_d      = '0;
          abort      = 1'b1;
        end else if (TIMEOUT != 0) begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, pointers, occupancy and latched head fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      tmr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      hd_xs_q    <= '0;
      hd_ys_q    <= '0;
      hd_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      tmr_q      <= tmr_d;
      if (accept && (state_q == StIdle)) begin
        hd_xs_q  <= in_data[XS_LSB +: COORD_W];
        hd_ys_q  <= in_data[YS_LSB +: COORD_W];
        hd_mis_q <= head_mis;
      end
      if (commit) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (commit && !pop)      occ_q <= occ_q + OCC_W'(1);
      else if (!commit && pop) occ_q <= occ_q - OCC_W'(1);
    end
  end

  // Packet storage and per-slot metadata; contents are don't-care until committed.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_data;
    if (commit) begin
      slot_xs_q[wr_ptr_q]  <= hd_xs_q;
      slot_ys_q[wr_ptr_q]  <= hd_ys_q;
      slot_mis_q[wr_ptr_q] <= hd_mis_q;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count   <= '0;
      err_count   <= '0;
      abort_count <= '0;
    end else if (cnt_clr) begin
      pkt_count   <= '0;
      err_count   <= '0;
      abort_count <= '0;
    end else begin
      if (commit)             pkt_count   <= sat_inc(pkt_count);
      if (commit && hd_mis_q) err_count   <= sat_inc(err_count);
      if (abort)              abort_count <= sat_inc(abort_count);
    end
  end

  // Read port for the oldest packet; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < int'(PKT_LEN)) rd_data = mem[rd_addr];
  end

  assign pkt_src_x    = slot_xs_q[rd_ptr_q];
  assign pkt_src_y    = slot_ys_q[rd_ptr_q];
  assign pkt_misroute = pkt_valid & slot_mis_q[rd_ptr_q];

endmodule

// File: tb/tb_noc_packet_sink.sv
// Scoreboard bench for noc_packet_sink: stimulus pushes expected packets,
// a negedge monitor pops and compares every packet the DUT hands over.
module tb_noc_packet_sink;

  typedef struct packed {
    logic [7:0][31:0] w;
    logic [6:0]       sx;
    logic [6:0]       sy;
    logic             mis;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic [6:0]  pkt_src_x, pkt_src_y;
  logic        pkt_misroute;
  logic        cnt_clr;
  logic [15:0] pkt_count, err_count, abort_count;

  // Saturation instance shares the input stream and always pops.
  logic        s_in_ready, s_pkt_valid, s_pkt_ready, s_pkt_misroute;
  logic [2:0]  s_rd_idx;
  logic [31:0] s_rd_data;
  logic [6:0]  s_src_x, s_src_y;
  logic [1:0]  s_pkt_count, s_err_count, s_abort_count;

  pkt_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #10 clk = ~clk;

  noc_packet_sink #(.LOCAL_X(3), .LOCAL_Y(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .rd_idx(rd_idx), .rd_data(rd_data),
    .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y), .pkt_misroute(pkt_misroute),
    .cnt_clr(cnt_clr), .pkt_count(pkt_count), .err_count(err_count),
    .abort_count(abort_count)
  );

  noc_packet_sink #(.LOCAL_X(3), .LOCAL_Y(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .pkt_valid(s_pkt_valid), .pkt_ready(s_pkt_ready), .rd_idx(s_rd_idx),
    .rd_data(s_rd_data), .pkt_src_x(s_src_x), .pkt_src_y(s_src_y),
    .pkt_misroute(s_pkt_misroute), .cnt_clr(cnt_clr), .pkt_count(s_pkt_count),
    .err_count(s_err_count), .abort_count(s_abort_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk_pkt(input int xd, input int yd, input int xs, input int ys,
                                  input logic [31:0] base);
    pkt_t p;
    p.w[0] = {7'(xd), 7'(yd), 7'(xs), 7'(ys), 4'h0};
    for (int i = 1; i < 8; i++) p.w[i] = base + 32'(i);
    p.sx  = 7'(xs);
    p.sy  = 7'(ys);
    p.mis = (xd != 3) || (yd != 5);
    return p;
  endfunction

  // Present one flit until accepted; returns at posedge+1 of the accepting edge.
  task automatic send_flit(input logic [31:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_wait", 32'(acc), 32'd1);
  endtask

  task automatic send_words(input pkt_t p, input int first, input int last);
    for (int i = first; i <= last; i++) send_flit(p.w[i]);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    while (!pkt_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pkt_valid) chk("pop_wait", 32'(pkt_valid), 32'd1);
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
  endtask

  task automatic clr_counters();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  // Monitor: on every pop, compare metadata and all words against the oldest expectation.
  initial begin
    pkt_t e;
    rd_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst && pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("src_x", 32'(pkt_src_x), 32'(e.sx));
          chk("src_y", 32'(pkt_src_y), 32'(e.sy));
          chk("misroute", 32'(pkt_misroute), 32'(e.mis));
          for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            chk($sformatf("word%0d", i), rd_data, e.w[i]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    pkt_t a, b, c;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    pkt_ready = 1'b0;
    cnt_clr = 1'b0;
    s_pkt_ready = 1'b1;
    s_rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_misroute", 32'(pkt_misroute), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_abort_count", 32'(abort_count), 32'd0);

    // Correctly routed packet, valid one cycle after the last flit
    a = mk_pkt(3, 5, 1, 2, 32'h0);
    exp_q.push_back(a);
    send_words(a, 0, 6);
    chk("t1_valid_before_last", 32'(pkt_valid), 32'd0);
    send_words(a, 7, 7);
    chk("t1_valid_after_last", 32'(pkt_valid), 32'd1);
    chk("t1_misroute", 32'(pkt_misroute), 32'd0);
    chk("t1_pkt_count", 32'(pkt_count), 32'd1);
    chk("t1_err_count", 32'(err_count), 32'd0);
    pop_one();

    // Misrouted packet (x_des = 4)
    clr_counters();
    chk("t2_clr", 32'(pkt_count), 32'd0);
    a = mk_pkt(4, 5, 1, 2, 32'h0);
    exp_q.push_back(a);
    send_words(a, 0, 7);
    chk("t2_misroute", 32'(pkt_misroute), 32'd1);
    chk("t2_err_count", 32'(err_count), 32'd1);
    chk("t2_pkt_count", 32'(pkt_count), 32'd1);
    pop_one();

    // Buffer full: third packet stalls until a pop frees a slot
    clr_counters();
    a = mk_pkt(3, 5, 10, 11, 32'h100);
    b = mk_pkt(3, 5, 20, 21, 32'h200);
    c = mk_pkt(3, 5, 30, 31, 32'h300);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    send_words(a, 0, 7);
    chk("t3_ready_after_1", 32'(in_ready), 32'd1);
    send_words(b, 0, 7);
    chk("t3_ready_full", 32'(in_ready), 32'd0);
    fork
      send_words(c, 0, 7);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("t3_ready_stalled", 32'(in_ready), 32'd0);
        chk("t3_count_stalled", 32'(pkt_count), 32'd2);
        pop_one();
        chk("t3_ready_after_pop", 32'(in_ready), 32'd1);
      end
    join
    chk("t3_count_done", 32'(pkt_count), 32'd3);
    pop_one();
    pop_one();
    @(posedge clk);
    #1;
    chk("t3_drained", 32'(pkt_valid), 32'd0);

    // Partial packet times out after 16 idle cycles
    a = mk_pkt(3, 5, 7, 7, 32'h400);
    send_words(a, 0, 3);
    repeat (16) @(posedge clk);
    #1;
    chk("t4_abort_count", 32'(abort_count), 32'd1);
    chk("t4_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("t4_pkt_count", 32'(pkt_count), 32'd3);
    a = mk_pkt(3, 5, 8, 9, 32'h500);
    exp_q.push_back(a);
    send_words(a, 0, 7);
    chk("t4_intact_count", 32'(pkt_count), 32'd4);
    pop_one();

    // Pop coincident with commit at occupancy 1
    a = mk_pkt(3, 5, 40, 41, 32'h600);
    b = mk_pkt(3, 5, 50, 51, 32'h700);
    exp_q.push_back(a);
    exp_q.push_back(b);
    send_words(a, 0, 7);
    send_words(b, 0, 6);
    pkt_ready = 1'b1;
    send_words(b, 7, 7);
    pkt_ready = 1'b0;
    chk("t5_valid_kept", 32'(pkt_valid), 32'd1);
    chk("t5_ready_kept", 32'(in_ready), 32'd1);
    pop_one();
    chk("t5_empty", 32'(pkt_valid), 32'd0);

    // Reset with a stored packet and a partial one in flight
    a = mk_pkt(3, 5, 1, 1, 32'h800);
    b = mk_pkt(4, 5, 2, 2, 32'h900);
    send_words(a, 0, 7);
    send_words(b, 0, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("t5_rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("t5_rst_err_count", 32'(err_count), 32'd0);
    chk("t5_rst_abort_count", 32'(abort_count), 32'd0);
    a = mk_pkt(3, 5, 3, 4, 32'hA00);
    exp_q.push_back(a);
    send_words(a, 0, 7);
    pop_one();

    // Saturating counters on the CNT_W = 2 instance
    clr_counters();
    chk("t6_clr", 32'(s_pkt_count), 32'd0);
    pkt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a = mk_pkt(4, 5, k, k + 1, 32'(k) << 8);
      exp_q.push_back(a);
      send_words(a, 0, 7);
    end
    repeat (2) @(posedge clk);
    #1;
    pkt_ready = 1'b0;
    chk("t6_sat_pkt", 32'(s_pkt_count), 32'd3);
    chk("t6_sat_err", 32'(s_err_count), 32'd3);
    chk("t6_sat_abort", 32'(s_abort_count), 32'd0);
    chk("t6_wide_pkt", 32'(pkt_count), 32'd5);
    chk("t6_wide_err", 32'(err_count), 32'd5);
    clr_counters();
    chk("t6_clr_pkt", 32'(s_pkt_count), 32'd0);
    chk("t6_clr_err", 32'(s_err_count), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
